// File: rtl/core_mem_responder_pkg.sv
// Shared types for the core memory responder: FSM states, grant owner, wait counter width.
package core_mem_responder_pkg;

  typedef enum logic [2:0] {
    IDLE,
    STROBE,
    WAIT,
    RDATA,
    ACK
  } state_t;

  typedef enum logic {
    GRANT_INSTR,
    GRANT_DATA
  } grant_t;

  // Wide enough for the largest wait-state count (15)
  localparam int CNT_W = 4;

endpackage

// File: rtl/core_mem_responder_rr_arbiter2.sv
// Two-requester round-robin arbiter. A lone requester always wins; on a tie the
// requester that did not win last time wins. The winner is only remembered when
// the owner actually takes the grant (grant_en), so the arbiter can sit in front
// of any multi-cycle resource.
import core_mem_responder_pkg::*;

module rr_arbiter2 (
  input  logic clk,
  input  logic reset,
  input  logic req_instr,
  input  logic req_data,
  input  logic grant_en,
  output logic grant_data,
  output logic grant_valid
);

  grant_t last_grant;

  // Pick the winner for this cycle from the requests and the previous winner
  always_comb begin
    grant_valid = req_instr | req_data;
    if (req_instr && req_data) begin
      grant_data = (last_grant == GRANT_INSTR);
    end else begin
      grant_data = req_data;
    end
  end

  // Remember who won whenever the grant is taken; instruction is "last" after reset so data wins the first tie
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= GRANT_INSTR;
    end else if (grant_en && grant_valid) begin
      last_grant <= grant_data ? GRANT_DATA : GRANT_INSTR;
    end
  end

endmodule

// File: rtl/core_mem_responder.sv
// Memory-side responder for the core's instruction and data buses. Arbitrates both
// onto one synchronous single-port RAM, strobes the RAM once per transaction and
// returns a one-cycle ack to the granted bus. All outputs are registered.
import core_mem_responder_pkg::*;

module core_mem_responder #(
  parameter int wait_states   = 0,
  parameter int ram_addr_bits = 19
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [18:0]              instr_m_addr,
  output logic [15:0]              instr_m_data_out,
  input  logic                     instr_m_access,
  output logic                     instr_m_ack,
  input  logic [18:0]              data_m_addr,
  input  logic [15:0]              data_m_data_in,
  output logic [15:0]              data_m_data_out,
  input  logic                     data_m_access,
  output logic                     data_m_ack,
  input  logic                     data_m_wr_en,
  input  logic [1:0]               data_m_bytesel,
  output logic                     ram_en,
  output logic [ram_addr_bits-1:0] ram_addr,
  output logic                     ram_wr_en,
  output logic [1:0]               ram_bytesel,
  output logic [15:0]              ram_wr_data,
  input  logic [15:0]              ram_rd_data
);

  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(wait_states);

  state_t           state;
  grant_t           grant_q;
  logic             wr_q;
  logic [CNT_W-1:0] wait_cnt;
  logic             arb_data;
  logic             arb_valid;

  rr_arbiter2 u_arb (
    .clk         (clk),
    .reset       (reset),
    .req_instr   (instr_m_access),
    .req_data    (data_m_access),
    .grant_en    (state == IDLE),
    .grant_data  (arb_data),
    .grant_valid (arb_valid)
  );

  // Transaction sequencer: latch the winner's request, strobe RAM, wait, capture read data, ack
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      grant_q          <= GRANT_INSTR;
      wr_q             <= 1'b0;
      wait_cnt         <= '0;
      ram_en           <= 1'b0;
      ram_wr_en        <= 1'b0;
      ram_addr         <= '0;
      ram_bytesel      <= 2'b00;
      ram_wr_data      <= 16'h0000;
      instr_m_data_out <= 16'h0000;
      data_m_data_out  <= 16'h0000;
      instr_m_ack      <= 1'b0;
      data_m_ack       <= 1'b0;
    end else begin
      ram_en      <= 1'b0;
      ram_wr_en   <= 1'b0;
      instr_m_ack <= 1'b0;
      data_m_ack  <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_valid) begin
            state  <= STROBE;
            ram_en <= 1'b1;
            if (arb_data) begin
              grant_q     <= GRANT_DATA;
              ram_addr    <= data_m_addr[ram_addr_bits-1:0];
              ram_wr_data <= data_m_data_in;
              ram_wr_en   <= data_m_wr_en;
              wr_q        <= data_m_wr_en;
              ram_bytesel <= data_m_wr_en ? data_m_bytesel : 2'b11;
            end else begin
              grant_q     <= GRANT_INSTR;
              ram_addr    <= instr_m_addr[ram_addr_bits-1:0];
              ram_wr_en   <= 1'b0;
              wr_q        <= 1'b0;
              ram_bytesel <= 2'b11;
            end
          end
        end
        STROBE: begin
          if (wait_states > 0) begin
            state    <= WAIT;
            wait_cnt <= WAIT_LOAD;
          end else begin
            state <= RDATA;
          end
        end
        WAIT: begin
          if (wait_cnt == CNT_W'(1)) begin
            state <= RDATA;
          end
          wait_cnt <= wait_cnt - 1'b1;
        end
        RDATA: begin
          if (!wr_q) begin
            if (grant_q == GRANT_DATA) begin
              data_m_data_out <= ram_rd_data;
            end else begin
              instr_m_data_out <= ram_rd_data;
            end
          end
          data_m_ack  <= (grant_q == GRANT_DATA);
          instr_m_ack <= (grant_q == GRANT_INSTR);
          state       <= ACK;
        end
        ACK: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
